// File: rtl/tx_arbiter.sv
// tx_arbiter: two-requester, packet-granular round-robin arbiter in front of a
// single byte-wide transmitter. Only the owner's tdata/tvalid are passed through
// combinationally, so there is no added latency once a grant is held.
// A packet longer than MAX_PKT beats is cut at MAX_PKT. The cut is recorded in a
// sticky err_trunc flag, and the requester's remaining beats go out as a new packet.

module tx_arbiter #(
  parameter int MAX_PKT = 256
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [7:0] s0_tdata,
  input  logic       s0_tvalid,
  input  logic       s0_tlast,
  output logic       s0_tready,
  input  logic [7:0] s1_tdata,
  input  logic       s1_tvalid,
  input  logic       s1_tlast,
  output logic       s1_tready,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  input  logic       m_tready,
  output logic [1:0] grant,
  output logic       err_trunc
);

  localparam int CW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PKT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [1:0]    r_grant;
  logic [1:0]    w_grant_nxt;
  logic          r_ptr;
  logic          w_ptr_nxt;
  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] w_beat_cnt_nxt;
  logic          r_err_trunc;
  logic          w_err_trunc_nxt;

  logic [7:0]    w_sel_tdata;
  logic          w_sel_tvalid;
  logic          w_sel_tlast;
  logic          w_xfer;
  logic          w_cnt_at_max;
  logic          w_beat;
  logic          w_arb_any;
  logic          w_arb_pick1;

  // Steer the current owner's signals onto the shared path. No owner means zeros.
  always_comb begin
    w_sel_tdata  = 8'h00;
    w_sel_tvalid = 1'b0;
    w_sel_tlast  = 1'b0;
    if (r_grant[1]) begin
      w_sel_tdata  = s1_tdata;
      w_sel_tvalid = s1_tvalid;
      w_sel_tlast  = s1_tlast;
    end else if (r_grant[0]) begin
      w_sel_tdata  = s0_tdata;
      w_sel_tvalid = s0_tvalid;
      w_sel_tlast  = s0_tlast;
    end
  end

  assign w_xfer       = (r_state == XFER);
  assign w_cnt_at_max = (r_beat_cnt == LAST_CNT);

  assign m_tdata   = w_xfer ? w_sel_tdata : 8'h00;
  assign m_tvalid  = w_xfer & w_sel_tvalid;
  assign m_tlast   = w_xfer & (w_sel_tlast | w_cnt_at_max);
  assign s0_tready = w_xfer & r_grant[0] & m_tready;
  assign s1_tready = w_xfer & r_grant[1] & m_tready;
  assign grant     = r_grant;
  assign err_trunc = r_err_trunc;

  assign w_beat = m_tvalid & m_tready;

  // The pointer breaks a tie only. A lone valid requester always wins.
  assign w_arb_any   = s0_tvalid | s1_tvalid;
  assign w_arb_pick1 = s1_tvalid & (~s0_tvalid | r_ptr);

  // Next-state logic: arbitrate in IDLE, and count beats until the last one in XFER.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_nxt       = r_ptr;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_err_trunc_nxt = r_err_trunc;
    case (r_state)
      IDLE: begin
        w_beat_cnt_nxt = '0;
        if (enable && w_arb_any) begin
          w_state_nxt = XFER;
          w_grant_nxt = w_arb_pick1 ? 2'b10 : 2'b01;
        end
      end
      XFER: begin
        if (w_beat) begin
          if (m_tlast) begin
            w_state_nxt    = IDLE;
            w_grant_nxt    = 2'b00;
            w_ptr_nxt      = r_grant[0];
            w_beat_cnt_nxt = '0;
            if (!w_sel_tlast) begin
              w_err_trunc_nxt = 1'b1;
            end
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = 2'b00;
      end
    endcase
  end

  // State register. Reset abandons any packet in flight and makes requester 0 preferred.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_grant     <= 2'b00;
      r_ptr       <= 1'b0;
      r_beat_cnt  <= '0;
      r_err_trunc <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_err_trunc <= w_err_trunc_nxt;
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter. Instance dut uses the default MAX_PKT.
// Instance dut4 uses MAX_PKT=4 so that truncation and the beat counter can be seen.
// Both instances share the same inputs. Inputs are driven on the falling edge,
// and outputs are sampled 1ns later.

module tb_tx_arbiter;

  logic       clk;
  logic       resetn;
  logic       enable;
  logic [7:0] s0_tdata;
  logic       s0_tvalid;
  logic       s0_tlast;
  logic [7:0] s1_tdata;
  logic       s1_tvalid;
  logic       s1_tlast;
  logic       m_tready;

  logic       s0Ready,  s1Ready,  mValid,  mLast,  errTrunc;
  logic [7:0] mData;
  logic [1:0] grantMain;
  logic       s0Ready4, s1Ready4, mValid4, mLast4, errTrunc4;
  logic [7:0] mData4;
  logic [1:0] grant4;

  logic [14:0] obsMain;
  logic [14:0] obs4;

  int compared;
  int mismatched;

  tx_arbiter #(.MAX_PKT(256)) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0Ready),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1Ready),
    .m_tdata(mData), .m_tvalid(mValid), .m_tlast(mLast), .m_tready(m_tready),
    .grant(grantMain), .err_trunc(errTrunc)
  );

  tx_arbiter #(.MAX_PKT(4)) dut4 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0Ready4),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1Ready4),
    .m_tdata(mData4), .m_tvalid(mValid4), .m_tlast(mLast4), .m_tready(m_tready),
    .grant(grant4), .err_trunc(errTrunc4)
  );

  assign obsMain = {errTrunc, grantMain, mValid, mLast, s0Ready, s1Ready, mData};
  assign obs4    = {errTrunc4, grant4, mValid4, mLast4, s0Ready4, s1Ready4, mData4};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus word: enable, m_tready, s0 valid/last/data, s1 valid/last/data
  function automatic logic [21:0] mkStim(logic en, logic mr, logic v0, logic l0,
                                         logic [7:0] d0, logic v1, logic l1, logic [7:0] d1);
    return {en, mr, v0, l0, d0, v1, l1, d1};
  endfunction

  // Expected word: err_trunc, grant, m_tvalid, m_tlast, s0_tready, s1_tready, m_tdata
  function automatic logic [14:0] mkExp(logic err, logic [1:0] g, logic v, logic l,
                                        logic r0, logic r1, logic [7:0] d);
    return {err, g, v, l, r0, r1, d};
  endfunction

  // Outputs stay quiet under reset, even when every input is active.
  task automatic test_reset();
    logic [21:0] st [3];
    st[0] = mkStim(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    st[1] = mkStim(1, 1, 1, 1, 8'h55, 1, 1, 8'h66);
    st[2] = mkStim(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      if (i == 2) resetn = 1'b1;
      #1;
      compared++;
      if (obsMain !== 15'h0) begin
        mismatched++;
        $display("[TB] FAIL reset[%0d] main: got %h expected %h", i, obsMain, 15'h0);
      end
      compared++;
      if (obs4 !== 15'h0) begin
        mismatched++;
        $display("[TB] FAIL reset[%0d] dut4: got %h expected %h", i, obs4, 15'h0);
      end
    end
  endtask

  // Both requesters contend: requester 0 goes first, then one idle cycle, then requester 1.
  task automatic test_both_requesters();
    logic [21:0] st [9];
    logic [14:0] ex [9];
    st[0] = mkStim(1, 1, 1, 0, 8'hA0, 1, 0, 8'hB0); ex[0] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[1] = mkStim(1, 1, 1, 0, 8'hA0, 1, 0, 8'hB0); ex[1] = mkExp(0, 2'b01, 1, 0, 1, 0, 8'hA0);
    st[2] = mkStim(1, 1, 1, 0, 8'hA1, 1, 0, 8'hB0); ex[2] = mkExp(0, 2'b01, 1, 0, 1, 0, 8'hA1);
    st[3] = mkStim(1, 1, 1, 1, 8'hA2, 1, 0, 8'hB0); ex[3] = mkExp(0, 2'b01, 1, 1, 1, 0, 8'hA2);
    st[4] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'hB0); ex[4] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[5] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'hB0); ex[5] = mkExp(0, 2'b10, 1, 0, 0, 1, 8'hB0);
    st[6] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'hB1); ex[6] = mkExp(0, 2'b10, 1, 0, 0, 1, 8'hB1);
    st[7] = mkStim(1, 1, 0, 0, 8'h00, 1, 1, 8'hB2); ex[7] = mkExp(0, 2'b10, 1, 1, 0, 1, 8'hB2);
    st[8] = mkStim(1, 1, 0, 0, 8'h00, 0, 0, 8'h00); ex[8] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      #1;
      compared++;
      if (obsMain !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL both[%0d] main: got %h expected %h", i, obsMain, ex[i]);
      end
      compared++;
      if (obs4 !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL both[%0d] dut4: got %h expected %h", i, obs4, ex[i]);
      end
    end
  endtask

  // Requester 0 alone wins every time, even when the pointer prefers requester 1.
  task automatic test_single_requester();
    logic [21:0] st [7];
    logic [14:0] ex [7];
    st[0] = mkStim(1, 1, 1, 0, 8'h10, 0, 0, 8'h00); ex[0] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[1] = mkStim(1, 1, 1, 0, 8'h10, 0, 0, 8'h00); ex[1] = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h10);
    st[2] = mkStim(1, 1, 1, 1, 8'h11, 0, 0, 8'h00); ex[2] = mkExp(0, 2'b01, 1, 1, 1, 0, 8'h11);
    st[3] = mkStim(1, 1, 1, 0, 8'h20, 0, 0, 8'h00); ex[3] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[4] = mkStim(1, 1, 1, 0, 8'h20, 0, 0, 8'h00); ex[4] = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h20);
    st[5] = mkStim(1, 1, 1, 1, 8'h21, 0, 0, 8'h00); ex[5] = mkExp(0, 2'b01, 1, 1, 1, 0, 8'h21);
    st[6] = mkStim(1, 1, 0, 0, 8'h00, 0, 0, 8'h00); ex[6] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      #1;
      compared++;
      if (obsMain !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL single[%0d] main: got %h expected %h", i, obsMain, ex[i]);
      end
      compared++;
      if (obs4 !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL single[%0d] dut4: got %h expected %h", i, obs4, ex[i]);
      end
    end
  endtask

  // m_tready toggles, and requester 1 waves tvalid while it is unselected. On dut4 a
  // beat counter that also counted stalled cycles would force m_tlast early.
  task automatic test_backpressure();
    logic [21:0] st [9];
    logic [14:0] ex [9];
    st[0] = mkStim(1, 1, 1, 0, 8'h30, 0, 0, 8'h00); ex[0] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[1] = mkStim(1, 1, 1, 0, 8'h30, 0, 0, 8'h00); ex[1] = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h30);
    st[2] = mkStim(1, 0, 1, 0, 8'h31, 1, 0, 8'hEE); ex[2] = mkExp(0, 2'b01, 1, 0, 0, 0, 8'h31);
    st[3] = mkStim(1, 1, 1, 0, 8'h31, 1, 0, 8'hEE); ex[3] = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h31);
    st[4] = mkStim(1, 0, 1, 0, 8'h32, 1, 0, 8'hEE); ex[4] = mkExp(0, 2'b01, 1, 0, 0, 0, 8'h32);
    st[5] = mkStim(1, 1, 1, 0, 8'h32, 0, 0, 8'h00); ex[5] = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h32);
    st[6] = mkStim(1, 0, 1, 1, 8'h33, 0, 0, 8'h00); ex[6] = mkExp(0, 2'b01, 1, 1, 0, 0, 8'h33);
    st[7] = mkStim(1, 1, 1, 1, 8'h33, 0, 0, 8'h00); ex[7] = mkExp(0, 2'b01, 1, 1, 1, 0, 8'h33);
    st[8] = mkStim(1, 1, 0, 0, 8'h00, 0, 0, 8'h00); ex[8] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      #1;
      compared++;
      if (obsMain !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL backpressure[%0d] main: got %h expected %h", i, obsMain, ex[i]);
      end
      compared++;
      if (obs4 !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL backpressure[%0d] dut4: got %h expected %h", i, obs4, ex[i]);
      end
    end
  endtask

  // Dropping enable mid-packet lets the packet finish but blocks the next grant. After
  // enable returns, the pointer picks requester 1, and two single-beat packets follow.
  task automatic test_enable_drop();
    logic [21:0] st [13];
    logic [14:0] ex [13];
    st[0]  = mkStim(1, 1, 1, 0, 8'h40, 0, 0, 8'h00); ex[0]  = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[1]  = mkStim(1, 1, 1, 0, 8'h40, 0, 0, 8'h00); ex[1]  = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h40);
    st[2]  = mkStim(0, 1, 1, 0, 8'h41, 0, 0, 8'h00); ex[2]  = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h41);
    st[3]  = mkStim(0, 1, 1, 0, 8'h42, 0, 0, 8'h00); ex[3]  = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h42);
    st[4]  = mkStim(0, 1, 1, 0, 8'h43, 0, 0, 8'h00); ex[4]  = mkExp(0, 2'b01, 1, 0, 1, 0, 8'h43);
    st[5]  = mkStim(0, 1, 1, 1, 8'h44, 0, 0, 8'h00); ex[5]  = mkExp(0, 2'b01, 1, 1, 1, 0, 8'h44);
    st[6]  = mkStim(0, 1, 1, 0, 8'h50, 1, 1, 8'h60); ex[6]  = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[7]  = mkStim(0, 1, 1, 0, 8'h50, 1, 1, 8'h60); ex[7]  = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[8]  = mkStim(1, 1, 1, 0, 8'h50, 1, 1, 8'h60); ex[8]  = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[9]  = mkStim(1, 1, 1, 0, 8'h50, 1, 1, 8'h60); ex[9]  = mkExp(0, 2'b10, 1, 1, 0, 1, 8'h60);
    st[10] = mkStim(1, 1, 1, 1, 8'h50, 0, 0, 8'h00); ex[10] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[11] = mkStim(1, 1, 1, 1, 8'h50, 0, 0, 8'h00); ex[11] = mkExp(0, 2'b01, 1, 1, 1, 0, 8'h50);
    st[12] = mkStim(1, 1, 0, 0, 8'h00, 0, 0, 8'h00); ex[12] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      #1;
      compared++;
      if (obsMain !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL enable[%0d] main: got %h expected %h", i, obsMain, ex[i]);
      end
    end
  endtask

  // Reset lands on beat 2 of a requester 1 packet. Outputs drop at once, and the first
  // contended arbitration afterward goes to requester 0.
  task automatic test_reset_mid_packet();
    logic [21:0] st [6];
    logic [14:0] ex [6];
    st[0] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h70); ex[0] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[1] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h70); ex[1] = mkExp(0, 2'b10, 1, 0, 0, 1, 8'h70);
    st[2] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h71); ex[2] = mkExp(0, 2'b10, 1, 0, 0, 1, 8'h71);
    st[3] = mkStim(1, 1, 1, 1, 8'h80, 1, 0, 8'h71); ex[3] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[4] = mkStim(1, 1, 1, 1, 8'h80, 1, 0, 8'h71); ex[4] = mkExp(0, 2'b01, 1, 1, 1, 0, 8'h80);
    st[5] = mkStim(1, 1, 0, 0, 8'h00, 0, 0, 8'h00); ex[5] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      #1;
      compared++;
      if (obsMain !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL resetmid[%0d] main: got %h expected %h", i, obsMain, ex[i]);
      end
    end
    // dut4 cut the 5-beat packet in the enable test, so its flag is still set
    compared++;
    if (errTrunc4 !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL resetmid sticky err dut4: got %b expected %b", errTrunc4, 1'b1);
    end
    resetn = 1'b0;
    #1;
    compared++;
    if (obsMain !== 15'h0) begin
      mismatched++;
      $display("[TB] FAIL resetmid async main: got %h expected %h", obsMain, 15'h0);
    end
    compared++;
    if (obs4 !== 15'h0) begin
      mismatched++;
      $display("[TB] FAIL resetmid async dut4: got %h expected %h", obs4, 15'h0);
    end
    @(negedge clk);
    {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = 22'h0;
    resetn = 1'b1;
    for (int i = 3; i < 6; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      #1;
      compared++;
      if (obsMain !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL resetmid[%0d] main: got %h expected %h", i, obsMain, ex[i]);
      end
    end
  endtask

  // On dut4, a 6-beat packet from requester 1 is cut at beat 4 and err_trunc sets. The
  // remaining two beats then go out as their own packet, and the flag stays set.
  task automatic test_truncation();
    logic [21:0] st [9];
    logic [14:0] ex [9];
    st[0] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h90); ex[0] = mkExp(0, 2'b00, 0, 0, 0, 0, 8'h00);
    st[1] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h90); ex[1] = mkExp(0, 2'b10, 1, 0, 0, 1, 8'h90);
    st[2] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h91); ex[2] = mkExp(0, 2'b10, 1, 0, 0, 1, 8'h91);
    st[3] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h92); ex[3] = mkExp(0, 2'b10, 1, 0, 0, 1, 8'h92);
    st[4] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h93); ex[4] = mkExp(0, 2'b10, 1, 1, 0, 1, 8'h93);
    st[5] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h94); ex[5] = mkExp(1, 2'b00, 0, 0, 0, 0, 8'h00);
    st[6] = mkStim(1, 1, 0, 0, 8'h00, 1, 0, 8'h94); ex[6] = mkExp(1, 2'b10, 1, 0, 0, 1, 8'h94);
    st[7] = mkStim(1, 1, 0, 0, 8'h00, 1, 1, 8'h95); ex[7] = mkExp(1, 2'b10, 1, 1, 0, 1, 8'h95);
    st[8] = mkStim(1, 1, 0, 0, 8'h00, 0, 0, 8'h00); ex[8] = mkExp(1, 2'b00, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = st[i];
      #1;
      compared++;
      if (obs4 !== ex[i]) begin
        mismatched++;
        $display("[TB] FAIL trunc[%0d] dut4: got %h expected %h", i, obs4, ex[i]);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    resetn     = 1'b0;
    {enable, m_tready, s0_tvalid, s0_tlast, s0_tdata, s1_tvalid, s1_tlast, s1_tdata} = 22'h0;
    $display("[TB] tx_arbiter directed tests starting");
    test_reset();
    test_both_requesters();
    test_single_requester();
    test_backpressure();
    test_enable_drop();
    test_reset_mid_packet();
    test_truncation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
